// File: rtl/expansion_mix_stage.sv
// ============================================================================
// Module      : expansion_mix_stage
// Description : Parametrised DES-style expansion with optional subkey XOR,
//               buffered in a 2-entry registered FIFO with valid/ready.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module expansion_mix_stage #(
  parameter int HALF_W  = 32,
  parameter int GROUP_W = 4,
  parameter int EXP_W   = HALF_W / GROUP_W * (GROUP_W + 2)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:HALF_W]  in_half,
  input  logic [1:EXP_W]   in_key,
  input  logic             key_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:EXP_W]   out_data,
  output logic [1:0]       occupancy
);

  localparam int N_GROUPS  = HALF_W / GROUP_W;
  localparam int GRP_OUT_W = GROUP_W + 2;

  if ((GROUP_W < 2) || (HALF_W % GROUP_W != 0) ||
      (EXP_W != N_GROUPS * GRP_OUT_W)) begin : g_bad_params
    $error("expansion_mix_stage: illegal HALF_W/GROUP_W/EXP_W combination");
  end

  logic [1:EXP_W] w_expanded;
  logic [1:EXP_W] w_mixed;
  logic           w_accept;
  logic           w_pop;

  logic [1:EXP_W] head_q, head_d;
  logic [1:EXP_W] tail_q, tail_d;
  logic [1:0]     count_q, count_d;

  // Each group copies its core bits and borrows one bit from each neighbour,
  // wrapping around the ends of the half block.
  for (genvar g = 0; g < N_GROUPS; g++) begin : g_expand
    localparam int OB    = g * GRP_OUT_W;
    localparam int LEFT  = (g == 0) ? HALF_W : g * GROUP_W;
    localparam int RIGHT = (g == N_GROUPS - 1) ? 1 : g * GROUP_W + GROUP_W + 1;

    assign w_expanded[OB + 1]            = in_half[LEFT];
    assign w_expanded[OB + 2 +: GROUP_W] = in_half[g * GROUP_W + 1 +: GROUP_W];
    assign w_expanded[OB + GROUP_W + 2]  = in_half[RIGHT];
  end

  assign w_mixed = key_en ? (w_expanded ^ in_key) : w_expanded;

  assign in_ready  = (count_q < 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign out_data  = head_q;
  assign occupancy = count_q;

  assign w_accept = in_valid && in_ready;
  assign w_pop    = out_valid && out_ready;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      count_d = 2'd0;
    end else begin
      case ({w_accept, w_pop})
        2'b10: begin
          if (count_q == 2'd0) head_d = w_mixed;
          else                 tail_d = w_mixed;
          count_d = count_q + 2'd1;
        end
        2'b01: begin
          head_d  = tail_q;
          count_d = count_q - 2'd1;
        end
        // Accept and pop together only happens with one entry held, so the
        // new result replaces the departing head directly.
        2'b11: begin
          head_d = (count_q == 2'd1) ? w_mixed : tail_q;
          if (count_q != 2'd1) tail_d = w_mixed;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= 2'd0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_expansion_mix_stage.sv
// ============================================================================
// Module      : tb_expansion_mix_stage
// Description : Randomised and directed checks of expansion_mix_stage against
//               a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_expansion_mix_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_half;
  logic [47:0] in_key;
  logic        key_en;
  logic        out_valid;
  logic        out_ready;
  logic [47:0] out_data;
  logic [1:0]  occupancy;

  logic        v16, rdy16, ov16, ordy16, ken16, fl16;
  logic [15:0] h16;
  logic [19:0] k16, od16;
  logic [1:0]  occ16;

  int n_checks = 0;
  int n_errors = 0;
  logic [47:0] q[$];

  always #5 clk = ~clk;

  expansion_mix_stage dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_half(in_half), .in_key(in_key), .key_en(key_en),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .occupancy(occupancy)
  );

  expansion_mix_stage #(.HALF_W(16), .GROUP_W(8)) dut16 (
    .clk(clk), .rst_n(rst_n), .flush(fl16),
    .in_valid(v16), .in_ready(rdy16),
    .in_half(h16), .in_key(k16), .key_en(ken16),
    .out_valid(ov16), .out_ready(ordy16),
    .out_data(od16), .occupancy(occ16)
  );

  // Expansion written straight from the group rule: bit positions are
  // 1-indexed from the MSB, neighbour indices wrap modulo hw.
  function automatic logic [63:0] exp_ref(input logic [63:0] x, input int hw, input int gw);
    int ew;
    int src;
    int dst;
    logic [63:0] r;
    ew = hw / gw * (gw + 2);
    r  = '0;
    for (int g = 0; g < hw / gw; g++) begin
      for (int k = 0; k <= gw + 1; k++) begin
        src = g * gw + k;
        if (src == 0) src = hw;
        if (src > hw) src = src - hw;
        dst = g * (gw + 2) + k + 1;
        r[ew - dst] = x[hw - src];
      end
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, ".occupancy"}, 64'(occupancy), 64'(q.size()));
    check({tag, ".in_ready"},  64'(in_ready),  64'(q.size() < 2));
    check({tag, ".out_valid"}, 64'(out_valid), 64'(q.size() != 0));
    if (q.size() != 0) check({tag, ".out_data"}, 64'(out_data), 64'(q[0]));
  endtask

  // Called at a negedge: drive one cycle, advance the model, check after the edge.
  task automatic drive_cycle(input string tag, input logic iv, input logic [31:0] h,
                             input logic [47:0] k, input logic ke, input logic ordy,
                             input logic fl);
    logic acc;
    logic pop;
    logic [47:0] e;
    in_valid  = iv;
    in_half   = h;
    in_key    = k;
    key_en    = ke;
    out_ready = ordy;
    flush     = fl;
    e   = 48'(exp_ref(64'(h), 32, 4));
    acc = iv && (q.size() < 2);
    pop = ordy && (q.size() != 0);
    if (fl) begin
      q.delete();
    end else begin
      if (pop) void'(q.pop_front());
      if (acc) q.push_back(ke ? (e ^ k) : e);
    end
    @(posedge clk);
    @(negedge clk);
    check_state(tag);
  endtask

  logic [31:0] ha, hb, hc;
  logic [47:0] kr;
  logic [19:0] e16;

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_half = '0; in_key = '0;
    key_en = 1'b0; out_ready = 1'b0;
    v16 = 1'b0; h16 = '0; k16 = '0; ken16 = 1'b0; ordy16 = 1'b1; fl16 = 1'b0;

    repeat (2) @(negedge clk);
    check("rst.out_valid", 64'(out_valid), 64'd0);
    check("rst.occupancy", 64'(occupancy), 64'd0);
    check("rst.in_ready",  64'(in_ready),  64'd1);
    check("rst.out_data",  64'(out_data),  64'd0);
    check("rst16.out_data", 64'(od16), 64'd0);
    rst_n = 1'b1;

    // Known-answer vectors
    drive_cycle("des_mix", 1'b1, 32'hF0AAF0AA, 48'h1B02EFFC7072, 1'b1, 1'b1, 1'b0);
    check("des_mix.kat", 64'(out_data), 64'h6117BA866527);
    drive_cycle("des_exp", 1'b1, 32'hF0AAF0AA, 48'h1B02EFFC7072, 1'b0, 1'b1, 1'b0);
    check("des_exp.kat", 64'(out_data), 64'h7A15557A1555);
    drive_cycle("wrap", 1'b1, 32'h00000001, 48'h0, 1'b0, 1'b1, 1'b0);
    check("wrap.kat", 64'(out_data), 64'h800000000002);
    drive_cycle("drain", 1'b0, 32'h0, 48'h0, 1'b0, 1'b1, 1'b0);

    // Back-pressure: third entry must be refused
    ha = $urandom(); hb = $urandom(); hc = $urandom();
    drive_cycle("bp_a", 1'b1, ha, 48'h0, 1'b0, 1'b0, 1'b0);
    drive_cycle("bp_b", 1'b1, hb, 48'h0, 1'b0, 1'b0, 1'b0);
    check("bp.full_ready", 64'(in_ready), 64'd0);
    drive_cycle("bp_c", 1'b1, hc, 48'h0, 1'b0, 1'b0, 1'b0);
    check("bp.still_full", 64'(occupancy), 64'd2);
    check("bp.head_a", 64'(out_data), exp_ref(64'(ha), 32, 4));
    drive_cycle("bp_pop1", 1'b0, 32'h0, 48'h0, 1'b0, 1'b1, 1'b0);
    check("bp.head_b", 64'(out_data), exp_ref(64'(hb), 32, 4));
    check("bp.occ1", 64'(occupancy), 64'd1);
    drive_cycle("bp_pop2", 1'b0, 32'h0, 48'h0, 1'b0, 1'b1, 1'b0);
    check("bp.occ0", 64'(occupancy), 64'd0);

    // Sustained streaming at occupancy 1
    drive_cycle("st_prime", 1'b1, $urandom(), 48'h0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      kr = {16'($urandom()), $urandom()};
      drive_cycle("stream", 1'b1, $urandom(), kr, 1'($urandom()), 1'b1, 1'b0);
      check("stream.occ", 64'(occupancy), 64'd1);
    end
    drive_cycle("st_drain", 1'b0, 32'h0, 48'h0, 1'b0, 1'b1, 1'b0);

    // Flush while full with a concurrent valid input
    drive_cycle("fl_a", 1'b1, $urandom(), 48'h0, 1'b0, 1'b0, 1'b0);
    drive_cycle("fl_b", 1'b1, $urandom(), 48'h0, 1'b0, 1'b0, 1'b0);
    drive_cycle("flush", 1'b1, $urandom(), 48'h0, 1'b0, 1'b1, 1'b1);
    check("flush.occ", 64'(occupancy), 64'd0);
    check("flush.valid", 64'(out_valid), 64'd0);
    check("flush.ready", 64'(in_ready), 64'd1);

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      kr = {16'($urandom()), $urandom()};
      drive_cycle("rand", 1'($urandom_range(0, 3) != 0), $urandom(), kr, 1'($urandom()),
                  1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 31) == 0));
    end

    // Asynchronous reset between edges
    drive_cycle("ar_a", 1'b1, $urandom(), 48'h0, 1'b0, 1'b0, 1'b0);
    drive_cycle("ar_b", 1'b1, $urandom(), 48'h0, 1'b0, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    q.delete();
    check("arst.out_valid", 64'(out_valid), 64'd0);
    check("arst.occupancy", 64'(occupancy), 64'd0);
    check("arst.out_data",  64'(out_data),  64'd0);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    drive_cycle("post_rst", 1'b1, 32'hF0AAF0AA, 48'h1B02EFFC7072, 1'b1, 1'b1, 1'b0);
    check("post_rst.kat", 64'(out_data), 64'h6117BA866527);
    for (int i = 0; i < 40; i++) begin
      kr = {16'($urandom()), $urandom()};
      drive_cycle("rand2", 1'($urandom()), $urandom(), kr, 1'($urandom()), 1'($urandom()), 1'b0);
    end

    // Narrow variant: 16-bit half, 8-bit groups
    v16 = 1'b1; h16 = 16'h8001; ken16 = 1'b0;
    @(posedge clk); @(negedge clk);
    v16 = 1'b0;
    check("v16.valid", 64'(ov16), 64'd1);
    check("v16.kat", 64'(od16), 64'h C0003);
    check("v16.model", 64'(od16), exp_ref(64'h8001, 16, 8));
    for (int i = 0; i < 6; i++) begin
      v16 = 1'b1; h16 = 16'($urandom()); k16 = 20'($urandom()); ken16 = 1'($urandom());
      e16 = 20'(exp_ref(64'(h16), 16, 8));
      if (ken16) e16 = e16 ^ k16;
      @(posedge clk); @(negedge clk);
      check("v16.rand", 64'(od16), 64'(e16));
      check("v16.occ", 64'(occ16), 64'd1);
    end
    v16 = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
